piso: RTL and testbench

//  Parallel-in serial-out word serializer; transmit-side counterpart of the sipo deserializer.

---
 rtl/piso_if.sv | 34 +++
 rtl/piso.sv | 98 +++++++++
 tb/tb_piso.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_if.sv
// Handshake bundle for the piso serializer: N-bit frame in, M-bit words out.
// The slave modport is the serializer's view; master is the frame source/word sink.
interface piso_if #(
    parameter int N = 1344,
    parameter int M = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] out_data;
    logic         out_last;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/piso.sv
// Parallel-in serial-out word serializer: one N-bit frame out as N/M words of M bits,
// word 0 first, with a zero-bubble reload on the final beat.
module piso #(
    parameter int N = 1344,
    parameter int M = 64
) (
    input  logic   clk,
    input  logic   rst_n,
    piso_if.slave  bus_io
);
    localparam int WORDS = N / M;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    // cnt value of the word just before the last one
    localparam logic [CW-1:0] PRE_LAST = CW'(WORDS - 2);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [N-1:0]  shift_q;
    logic [N-1:0]  shift_d;
    logic [M-1:0]  data_q;
    logic          valid_q;
    logic          last_q;

    logic          beat;
    logic          load;
    logic          in_ready;
    logic [M-1:0]  frame_lo;
    logic [N-1:0]  frame_hi;

    assign beat     = valid_q & bus_io.out_ready;
    assign in_ready = (state_q == IDLE) | (beat & last_q);
    assign load     = bus_io.in_valid & in_ready;

    assign frame_lo = bus_io.in_data[M-1:0];
    assign frame_hi = bus_io.in_data >> M;
    assign cnt_d    = cnt_q + 1'b1;
    assign shift_d  = shift_q >> M;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        shift_q <= frame_hi;
                        data_q  <= frame_lo;
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                        last_q  <= 1'b0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (beat) begin
                        if (!last_q) begin
                            data_q  <= shift_q[M-1:0];
                            shift_q <= shift_d;
                            cnt_q   <= cnt_d;
                            last_q  <= (cnt_q == PRE_LAST);
                        end else if (load) begin
                            // next frame rides in on the last beat: no bubble
                            shift_q <= frame_hi;
                            data_q  <= frame_lo;
                            valid_q <= 1'b1;
                            cnt_q   <= '0;
                            last_q  <= 1'b0;
                        end else begin
                            data_q  <= '0;
                            valid_q <= 1'b0;
                            cnt_q   <= '0;
                            last_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_io.in_ready  = in_ready;
    assign bus_io.out_valid = valid_q;
    assign bus_io.out_data  = data_q;
    assign bus_io.out_last  = last_q;
endmodule

// File: tb/tb_piso.sv
// Directed bench for piso: vector table for load/stall/reject, then
// hand-written sequences for full frames, backpressure, back-to-back and async reset.
module tb_piso;
    localparam int N     = 1344;
    localparam int M     = 64;
    localparam int WORDS = N / M;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    piso_if #(.N(N), .M(M)) bus ();

    piso #(.N(N), .M(M)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         iv;
        logic [15:0]  base;
        logic         ordy;
        logic         ev;
        logic [63:0]  ed;
        logic         el;
        logic         er;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [N-1:0] mkf(input logic [M-1:0] base);
        logic [N-1:0] f;
        f = '0;
        for (int k = 0; k < WORDS; k++) f[k*M +: M] = base + M'(k);
        return f;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [M-1:0] base,
                         input logic ordy);
        bus.in_valid  = iv;
        bus.in_data   = iv ? mkf(base) : '0;
        bus.out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, ".ov"}, 64'(bus.out_valid), 64'd0);
        chk({nm, ".od"}, bus.out_data, 64'd0);
        chk({nm, ".ol"}, 64'(bus.out_last), 64'd0);
        chk({nm, ".ir"}, 64'(bus.in_ready), 64'd1);
    endtask

    task automatic chk_word(input string nm, input logic [63:0] w,
                            input logic l, input logic ir);
        chk({nm, ".ov"}, 64'(bus.out_valid), 64'd1);
        chk({nm, ".od"}, bus.out_data, w);
        chk({nm, ".ol"}, 64'(bus.out_last), 64'(l));
        chk({nm, ".ir"}, 64'(bus.in_ready), 64'(ir));
    endtask

    initial begin
        int k;
        int cyc;
        logic ordy;
        total = 0;
        bad   = 0;

        tbl[0] = '{1'b0, 16'h0000, 1'b0, 1'b0, 64'h0,    1'b0, 1'b1};
        tbl[1] = '{1'b1, 16'h1000, 1'b0, 1'b0, 64'h0,    1'b0, 1'b1};
        tbl[2] = '{1'b0, 16'h0000, 1'b0, 1'b1, 64'h1000, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 16'h0000, 1'b0, 1'b1, 64'h1000, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 64'h1000, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 64'h1001, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 16'h0000, 1'b0, 1'b1, 64'h1002, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 16'h3000, 1'b0, 1'b1, 64'h1002, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 16'h3000, 1'b1, 1'b1, 64'h1002, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 16'h0000, 1'b1, 1'b1, 64'h1003, 1'b0, 1'b0};

        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_idle("reset");

        // table: load, stalls, busy reject, beats
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].iv, 64'(tbl[i].base), tbl[i].ordy);
            chk($sformatf("tbl%0d.ov", i), 64'(bus.out_valid), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d.od", i), bus.out_data, tbl[i].ed);
            chk($sformatf("tbl%0d.ol", i), 64'(bus.out_last), 64'(tbl[i].el));
            chk($sformatf("tbl%0d.ir", i), 64'(bus.in_ready), 64'(tbl[i].er));
            tick();
        end
        for (int w = 4; w < WORDS; w++) begin
            drive(1'b0, '0, 1'b1);
            chk_word($sformatf("tdrain%0d", w), 64'h1000 + 64'(w),
                     w == WORDS - 1, w == WORDS - 1);
            tick();
        end
        drive(1'b0, '0, 1'b0);
        chk_idle("tdone");

        // single frame, out_ready held high
        drive(1'b1, 64'h1000, 1'b1);
        chk("single.ir", 64'(bus.in_ready), 64'd1);
        tick();
        for (int w = 0; w < WORDS; w++) begin
            drive(1'b0, '0, 1'b1);
            chk_word($sformatf("single%0d", w), 64'h1000 + 64'(w),
                     w == WORDS - 1, w == WORDS - 1);
            tick();
        end
        drive(1'b0, '0, 1'b0);
        chk_idle("single.end");

        // backpressure 1,0,0,1,0,0,...
        drive(1'b1, 64'h1000, 1'b0);
        tick();
        k = 0;
        cyc = 0;
        while (k < WORDS && cyc < 200) begin
            ordy = (cyc % 3 == 0);
            drive(1'b0, '0, ordy);
            chk($sformatf("bp%0d.ov", cyc), 64'(bus.out_valid), 64'd1);
            chk($sformatf("bp%0d.od", cyc), bus.out_data, 64'h1000 + 64'(k));
            chk($sformatf("bp%0d.ol", cyc), 64'(bus.out_last),
                64'(k == WORDS - 1));
            if (ordy) k++;
            tick();
            cyc++;
        end
        chk("bp.timeout", 64'(k), 64'(WORDS));
        drive(1'b0, '0, 1'b0);
        chk_idle("bp.end");

        // back-to-back A then B, no bubble
        drive(1'b1, 64'h1000, 1'b1);
        tick();
        for (int c = 0; c < 2 * WORDS; c++) begin
            if (c == WORDS - 1) drive(1'b1, 64'h2000, 1'b1);
            else drive(1'b0, '0, 1'b1);
            if (c < WORDS)
                chk_word($sformatf("b2bA%0d", c), 64'h1000 + 64'(c),
                         c == WORDS - 1, c == WORDS - 1);
            else
                chk_word($sformatf("b2bB%0d", c - WORDS),
                         64'h2000 + 64'(c - WORDS),
                         c == 2 * WORDS - 1, c == 2 * WORDS - 1);
            tick();
        end
        drive(1'b0, '0, 1'b0);
        chk_idle("b2b.end");

        // busy reject: C offered from A's beat 5, held until taken
        drive(1'b1, 64'h1000, 1'b1);
        tick();
        for (int w = 0; w < WORDS; w++) begin
            if (w >= 5) drive(1'b1, 64'h3000, 1'b1);
            else drive(1'b0, '0, 1'b1);
            chk_word($sformatf("rejA%0d", w), 64'h1000 + 64'(w),
                     w == WORDS - 1, w == WORDS - 1);
            tick();
        end
        k = 0;
        cyc = 0;
        while (bus.out_valid && cyc < 100) begin
            drive(1'b0, '0, 1'b1);
            if (bus.out_valid) begin
                chk($sformatf("rejC%0d.od", k), bus.out_data, 64'h3000 + 64'(k));
                k++;
            end
            tick();
            cyc++;
        end
        chk("rejC.count", 64'(k), 64'(WORDS));
        drive(1'b0, '0, 1'b0);
        chk_idle("rej.end");

        // async reset after beat 10
        drive(1'b1, 64'h1000, 1'b1);
        tick();
        for (int w = 0; w < 10; w++) begin
            drive(1'b0, '0, 1'b1);
            chk($sformatf("rst%0d.od", w), bus.out_data, 64'h1000 + 64'(w));
            tick();
        end
        drive(1'b0, '0, 1'b0);
        chk_word("rst.pre", 64'h100a, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.async.ov", 64'(bus.out_valid), 64'd0);
        chk("rst.async.od", bus.out_data, 64'd0);
        chk("rst.async.ol", 64'(bus.out_last), 64'd0);
        drive(1'b1, 64'h5000, 1'b1);
        tick();
        chk("rst.noload.ov", 64'(bus.out_valid), 64'd0);
        drive(1'b0, '0, 1'b0);
        rst_n = 1'b1;
        #1;
        chk_idle("rst.rel");
        drive(1'b1, 64'h4000, 1'b1);
        tick();
        for (int w = 0; w < WORDS; w++) begin
            drive(1'b0, '0, 1'b1);
            chk_word($sformatf("rstD%0d", w), 64'h4000 + 64'(w),
                     w == WORDS - 1, w == WORDS - 1);
            tick();
        end
        drive(1'b0, '0, 1'b0);
        chk_idle("rstD.end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
